noise_cfg_ctrl: RTL and testbench
=================================

Name: noise_cfg_ctrl

Overview:
SPI-fed configuration controller for the noise generator datapath. It receives 40-bit command frames from the MCU and checks frame length and opcode. Valid updates are held in shadow registers. The controller applies them to the generator only at a safe point: a divider-wrap tick from the datapath, or immediately when the generator is disabled. The datapath therefore never sees a half-written divisor or seed.

Parameters:
FREQ_RST, 13000, reset value of freq_div
SEED_RST, 111, reset value of seed; also replaces any all-zero seed
TICK_TIMEOUT, 131071, sys_clk cycles to wait for gen_tick before forcing apply

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
spi_clock  in  1  SPI SCK, mode 0, async to sys_clk
spi_data  in  1  SPI MOSI, MSB first
spi_cs  in  1  SPI chip select, active low
gen_tick  in  1  1-cycle pulse from datapath when its divider wraps
freq_div  out  17  active divisor to datapath
seed  out  23  LFSR seed to datapath
seed_load  out  1  1-cycle strobe: datapath loads seed
gen_enable  out  1  datapath run enable
cfg_busy  out  1  high while an update is pending or being applied
frame_err  out  1  sticky; set on a bad frame, cleared by CTRL opcode bit1
err_count  out  8  saturating bad-frame counter

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is sys_rst_n, asynchronous active-low. It clears all state and returns the FSM to IDLE.
- Reset values: freq_div=FREQ_RST, seed=SEED_RST, seed_load=0, gen_enable=0, cfg_busy=0, frame_err=0, err_count=0.
- Synchronisers: 3-flop for spi_clock and spi_cs; 2-flop for spi_data.
- Edge detection: SCK rise = sync[2:1]==01. CS fall = sync[2:1]==10, CS rise = sync[2:1]==01.
- Frame format, bits [39:0]: [39:32] opcode, [31:0] payload.
  - 0x01 FREQ: payload[16:0] goes to shadow freq.
  - 0x02 SEED: payload[22:0] goes to shadow seed.
  - 0x03 CTRL: payload[0] = enable; payload[1]=1 clears frame_err and err_count.
  - Any other opcode is an error.
- FSM states: IDLE, RECV, CHECK, PENDING, APPLY.
  - IDLE -> RECV on CS fall. The 6-bit bit counter clears.
  - RECV: each SCK rise shifts MOSI into the 40-bit shift register, LSB end. The bit counter increments and saturates at 63.
  - RECV -> CHECK on CS rise.
  - CHECK, one cycle:
    - If bitcnt!=40 or the opcode is unknown: set frame_err, increment err_count (saturates at 255), go to IDLE. Shadows stay untouched.
    - If CTRL: apply enable and error-clear in this cycle, go to IDLE. No tick wait.
    - If FREQ or SEED: load the shadow, set cfg_busy, go to PENDING.
  - PENDING: go to APPLY on the first of these:
    - gen_tick=1
    - gen_enable=0 (no wait)
    - the wait counter reaches TICK_TIMEOUT
  - APPLY, one cycle:
    - FREQ: freq_div <= shadow.
    - SEED: seed <= shadow, except an all-zero shadow loads SEED_RST. seed_load=1 for exactly this cycle.
    - Clear cfg_busy, go to IDLE.
- Latency, CS rise on the pin to freq_div change with gen_enable=0: 3 sync cycles + CHECK + PENDING + APPLY = freq_div updated on the 6th sys_clk edge.
- CS fall while in PENDING: the update stays pending, the new frame is ignored, and err_count increments once at its CS rise. At most one outstanding update; no queueing.
- SCK edges while CS is high are ignored. A CS rise with no SCK edges (bitcnt=0) counts as an error.
- gen_tick in IDLE/RECV/CHECK is ignored.
- Reset mid-frame or mid-PENDING: the shadow update is discarded and outputs return to reset values.

Test Plan:
- Reset, no SPI activity -> freq_div=13000, seed=111, gen_enable=0, seed_load=0, cfg_busy=0.
- Frame 0x01_00000FA0 with gen_enable=0 -> freq_div=4000 within 6 cycles of CS rise; cfg_busy high exactly 2 cycles; no seed_load.
- CTRL enable=1, then SEED 0x02_00001234, gen_tick held low for 50 cycles then pulsed -> seed stays 111 until the tick; seed=0x1234 and a single seed_load pulse in the APPLY cycle after the tick.
- SEED payload 0 with gen_enable=0 -> seed=111 and seed_load pulses once.
- 39-bit frame, then 41-bit frame, then opcode 0x7F -> err_count=3, frame_err=1, freq_div and seed unchanged; CTRL 0x03_00000002 -> err_count=0, frame_err=0.
- gen_enable=1 with no gen_tick -> FREQ update applies after exactly TICK_TIMEOUT cycles in PENDING; a second frame sent during PENDING -> err_count+1 and only the first value applied.

Source files
------------

// File: rtl/noise_cfg_ctrl.sv
// SPI-fed configuration controller for the noise generator: receives 40-bit frames,
// validates them, and hands divisor/seed updates to the datapath only at safe points.
module noise_cfg_ctrl #(
    parameter logic [16:0] FREQ_RST     = 17'd13000,
    parameter logic [22:0] SEED_RST     = 23'd111,
    parameter int          TICK_TIMEOUT = 131071
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        spi_clock,
    input  logic        spi_data,
    input  logic        spi_cs,
    input  logic        gen_tick,
    output logic [16:0] freq_div,
    output logic [22:0] seed,
    output logic        seed_load,
    output logic        gen_enable,
    output logic        cfg_busy,
    output logic        frame_err,
    output logic [7:0]  err_count,
    output logic [2:0]  dbg_state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RECV    = 3'd1;
    localparam logic [2:0] S_CHECK   = 3'd2;
    localparam logic [2:0] S_PENDING = 3'd3;
    localparam logic [2:0] S_APPLY   = 3'd4;

    localparam logic [7:0] OP_FREQ = 8'h01;
    localparam logic [7:0] OP_SEED = 8'h02;
    localparam logic [7:0] OP_CTRL = 8'h03;

    localparam int                WAIT_W    = $clog2(TICK_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TICK_TIMEOUT - 1);

    logic [2:0]        r_sck_sync;
    logic [2:0]        r_cs_sync;
    logic [1:0]        r_mosi_sync;
    logic [2:0]        r_state;
    logic [39:0]       r_shift;
    logic [5:0]        r_bitcnt;
    logic [16:0]       r_shadow_freq;
    logic [22:0]       r_shadow_seed;
    logic              r_pend_seed;
    logic [WAIT_W-1:0] r_wait;
    logic [16:0]       r_freq_div;
    logic [22:0]       r_seed;
    logic              r_seed_load;
    logic              r_gen_enable;
    logic              r_cfg_busy;
    logic              r_frame_err;
    logic [7:0]        r_err_count;
    logic              r_drop;

    logic       w_sck_rise;
    logic       w_cs_fall;
    logic       w_cs_rise;
    logic [7:0] w_opcode;
    logic       w_op_known;
    logic       w_frame_bad;
    logic       w_ctrl_clear;
    logic       w_err_inc;
    logic       w_go_apply;

    assign w_sck_rise   = (r_sck_sync[2:1] == 2'b01);
    assign w_cs_fall    = (r_cs_sync[2:1] == 2'b10);
    assign w_cs_rise    = (r_cs_sync[2:1] == 2'b01);
    assign w_opcode     = r_shift[39:32];
    assign w_op_known   = (w_opcode == OP_FREQ) || (w_opcode == OP_SEED) || (w_opcode == OP_CTRL);
    assign w_frame_bad  = (r_bitcnt != 6'd40) || !w_op_known;
    assign w_ctrl_clear = (r_state == S_CHECK) && !w_frame_bad && (w_opcode == OP_CTRL) && r_shift[1];
    // A frame arriving while an update is outstanding is counted as bad when it closes.
    assign w_err_inc    = ((r_state == S_CHECK) && w_frame_bad) || (w_cs_rise && r_drop);
    assign w_go_apply   = gen_tick || !r_gen_enable || (r_wait == WAIT_LAST);

    // CS idles high, so its synchroniser resets to ones to avoid a false edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sck_sync  <= 3'b000;
            r_cs_sync   <= 3'b111;
            r_mosi_sync <= 2'b00;
        end else begin
            r_sck_sync  <= {r_sck_sync[1:0], spi_clock};
            r_cs_sync   <= {r_cs_sync[1:0], spi_cs};
            r_mosi_sync <= {r_mosi_sync[0], spi_data};
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_drop <= 1'b0;
        end else if (w_cs_rise) begin
            r_drop <= 1'b0;
        end else if (w_cs_fall && (r_state != S_IDLE)) begin
            r_drop <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_frame_err <= 1'b0;
            r_err_count <= 8'd0;
        end else if (w_ctrl_clear) begin
            r_frame_err <= 1'b0;
            r_err_count <= 8'd0;
        end else if (w_err_inc) begin
            r_frame_err <= 1'b1;
            if (r_err_count != 8'hFF) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state       <= S_IDLE;
            r_shift       <= 40'd0;
            r_bitcnt      <= 6'd0;
            r_shadow_freq <= 17'd0;
            r_shadow_seed <= 23'd0;
            r_pend_seed   <= 1'b0;
            r_wait        <= '0;
            r_freq_div    <= FREQ_RST;
            r_seed        <= SEED_RST;
            r_seed_load   <= 1'b0;
            r_gen_enable  <= 1'b0;
            r_cfg_busy    <= 1'b0;
        end else begin
            r_seed_load <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cs_fall) begin
                        r_bitcnt <= 6'd0;
                        r_state  <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (w_cs_rise) begin
                        r_state <= S_CHECK;
                    end else if (w_sck_rise) begin
                        r_shift <= {r_shift[38:0], r_mosi_sync[1]};
                        if (r_bitcnt != 6'd63) begin
                            r_bitcnt <= r_bitcnt + 6'd1;
                        end
                    end
                end
                S_CHECK: begin
                    r_state <= S_IDLE;
                    if (!w_frame_bad) begin
                        case (w_opcode)
                            OP_CTRL: begin
                                r_gen_enable <= r_shift[0];
                            end
                            OP_FREQ: begin
                                r_shadow_freq <= r_shift[16:0];
                                r_pend_seed   <= 1'b0;
                                r_cfg_busy    <= 1'b1;
                                r_wait        <= '0;
                                r_state       <= S_PENDING;
                            end
                            OP_SEED: begin
                                r_shadow_seed <= r_shift[22:0];
                                r_pend_seed   <= 1'b1;
                                r_cfg_busy    <= 1'b1;
                                r_wait        <= '0;
                                r_state       <= S_PENDING;
                            end
                            default: r_state <= S_IDLE;
                        endcase
                    end
                end
                S_PENDING: begin
                    if (w_go_apply) begin
                        r_state <= S_APPLY;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_APPLY: begin
                    // Seed and its load strobe become visible together on the same edge.
                    if (r_pend_seed) begin
                        r_seed      <= (r_shadow_seed == 23'd0) ? SEED_RST : r_shadow_seed;
                        r_seed_load <= 1'b1;
                    end else begin
                        r_freq_div <= r_shadow_freq;
                    end
                    r_cfg_busy <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign freq_div   = r_freq_div;
    assign seed       = r_seed;
    assign seed_load  = r_seed_load;
    assign gen_enable = r_gen_enable;
    assign cfg_busy   = r_cfg_busy;
    assign frame_err  = r_frame_err;
    assign err_count  = r_err_count;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_noise_cfg_ctrl.sv
// Bench for noise_cfg_ctrl: directed scenarios followed by random frames checked
// against a frame-level model of the controller's registers.
module tb_noise_cfg_ctrl;

    localparam int T = 400;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        spi_clock;
    logic        spi_data;
    logic        spi_cs;
    logic        gen_tick;
    logic [16:0] freq_div;
    logic [22:0] seed;
    logic        seed_load;
    logic        gen_enable;
    logic        cfg_busy;
    logic        frame_err;
    logic [7:0]  err_count;
    logic [2:0]  dbg_state;

    int vectors     = 0;
    int miscompares = 0;

    logic [16:0] m_freq;
    logic [22:0] m_seed;
    logic        m_en;
    logic        m_ferr;
    int          m_err;
    logic [63:0] exp_q[$];

    noise_cfg_ctrl #(
        .FREQ_RST    (17'd13000),
        .SEED_RST    (23'd111),
        .TICK_TIMEOUT(T)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .spi_clock (spi_clock),
        .spi_data  (spi_data),
        .spi_cs    (spi_cs),
        .gen_tick  (gen_tick),
        .freq_div  (freq_div),
        .seed      (seed),
        .seed_load (seed_load),
        .gen_enable(gen_enable),
        .cfg_busy  (cfg_busy),
        .frame_err (frame_err),
        .err_count (err_count),
        .dbg_state (dbg_state)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Mode-0 SPI master, MSB first, two sys_clk cycles per SCK phase.
    task automatic send_frame(input logic [63:0] data, input int nbits);
        @(negedge sys_clk);
        spi_clock = 1'b0;
        spi_cs    = 1'b0;
        repeat (4) @(negedge sys_clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_data = data[i];
            repeat (2) @(negedge sys_clk);
            spi_clock = 1'b1;
            repeat (2) @(negedge sys_clk);
            spi_clock = 1'b0;
        end
        repeat (4) @(negedge sys_clk);
        spi_cs = 1'b1;
    endtask

    task automatic send40(input logic [39:0] f);
        send_frame({24'd0, f}, 40);
    endtask

    task automatic settle();
        repeat (8) @(negedge sys_clk);
    endtask

    task automatic model_bad();
        m_ferr = 1'b1;
        if (m_err < 255) m_err++;
    endtask

    task automatic model_reset();
        m_freq = 17'd13000;
        m_seed = 23'd111;
        m_en   = 1'b0;
        m_ferr = 1'b0;
        m_err  = 0;
    endtask

    initial begin
        int          first;
        int          busy_n;
        int          sl_n;
        int          bad_n;
        logic [22:0] seed_at;
        logic [31:0] pay;
        logic [7:0]  op;
        int          kind;
        int          nb;

        sys_rst_n = 1'b0;
        spi_clock = 1'b0;
        spi_data  = 1'b0;
        spi_cs    = 1'b1;
        gen_tick  = 1'b0;
        model_reset();
        repeat (5) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);

        check("rst_freq", freq_div, m_freq);
        check("rst_seed", seed, m_seed);
        check("rst_enable", gen_enable, 0);
        check("rst_seed_load", seed_load, 0);
        check("rst_busy", cfg_busy, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_err_count", err_count, 0);

        // FREQ with generator disabled: applies on the 6th edge after CS rise.
        send40(40'h01_00000FA0);
        first = 0; busy_n = 0; sl_n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge sys_clk); #1;
            if (first == 0 && freq_div !== m_freq) first = i;
            busy_n += int'(cfg_busy);
            sl_n   += int'(seed_load);
        end
        m_freq = 17'd4000;
        check("freq_latency", first, 6);
        check("freq_value", freq_div, m_freq);
        check("freq_busy_cycles", busy_n, 2);
        check("freq_no_seed_load", sl_n, 0);

        // SEED with generator enabled waits for gen_tick.
        send40(40'h03_00000001);
        settle();
        m_en = 1'b1;
        check("ctrl_enable", gen_enable, 1);
        send40(40'h02_00001234);
        bad_n = 0;
        repeat (50) begin
            @(posedge sys_clk); #1;
            if (seed !== 23'd111 || seed_load !== 1'b0) bad_n++;
        end
        check("seed_held_before_tick", bad_n, 0);
        check("busy_while_pending", cfg_busy, 1);
        @(negedge sys_clk); gen_tick = 1'b1;
        @(negedge sys_clk); gen_tick = 1'b0;
        sl_n = 0; seed_at = '0;
        repeat (10) begin
            @(posedge sys_clk); #1;
            if (seed_load === 1'b1) begin
                sl_n++;
                seed_at = seed;
            end
        end
        m_seed = 23'h1234;
        check("tick_seed_load_pulses", sl_n, 1);
        check("tick_seed_at_load", seed_at, m_seed);
        check("tick_seed_final", seed, m_seed);
        check("tick_busy_clear", cfg_busy, 0);

        // All-zero seed falls back to the reset seed.
        send40(40'h03_00000000);
        settle();
        m_en = 1'b0;
        check("ctrl_disable", gen_enable, 0);
        send40(40'h02_00000000);
        sl_n = 0; seed_at = '0;
        repeat (12) begin
            @(posedge sys_clk); #1;
            if (seed_load === 1'b1) begin
                sl_n++;
                seed_at = seed;
            end
        end
        m_seed = 23'd111;
        check("zero_seed_load_pulses", sl_n, 1);
        check("zero_seed_at_load", seed_at, m_seed);

        // Bad length (39, 41) and unknown opcode.
        send_frame(64'h01_00000055, 39);
        settle();
        model_bad();
        send_frame(64'h01_00000055, 41);
        settle();
        model_bad();
        send40(40'h7F_12345678);
        settle();
        model_bad();
        check("bad_err_count", err_count, m_err);
        check("bad_frame_err", frame_err, m_ferr);
        check("bad_freq_kept", freq_div, m_freq);
        check("bad_seed_kept", seed, m_seed);
        send40(40'h03_00000002);
        settle();
        m_ferr = 1'b0; m_err = 0;
        check("clear_err_count", err_count, 0);
        check("clear_frame_err", frame_err, 0);

        // Enabled with no tick: timeout forces the apply; a frame during PENDING is rejected.
        send40(40'h03_00000001);
        settle();
        m_en = 1'b1;
        send40(40'h01_00001111);
        first = 0;
        fork
            begin
                for (int i = 1; i <= T + 60; i++) begin
                    @(posedge sys_clk); #1;
                    if (freq_div !== m_freq) begin
                        first = i;
                        break;
                    end
                end
            end
            begin
                repeat (10) @(negedge sys_clk);
                send40(40'h01_00002222);
            end
        join
        m_freq = 17'h1111;
        check("timeout_latency", first, T + 5);
        check("timeout_freq", freq_div, m_freq);
        settle();
        check("pending_drop_err_count", err_count, 1);
        check("pending_drop_freq", freq_div, m_freq);
        send40(40'h03_00000003);
        settle();
        m_ferr = 1'b0; m_err = 0;
        check("reclear_err_count", err_count, 0);
        check("reclear_enable", gen_enable, 1);

        // Reset while an update is pending discards it.
        send40(40'h01_00003333);
        repeat (20) @(negedge sys_clk);
        check("pre_reset_busy", cfg_busy, 1);
        sys_rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_freq", freq_div, m_freq);
        check("midrst_seed", seed, m_seed);
        check("midrst_enable", gen_enable, 0);
        check("midrst_busy", cfg_busy, 0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (T + 20) @(negedge sys_clk);
        check("postrst_freq", freq_div, m_freq);

        // Random frames against the model.
        for (int it = 0; it < 30; it++) begin
            kind = $urandom_range(0, 5);
            pay  = $urandom;
            nb   = 40;
            op   = 8'h00;
            case (kind)
                0: begin op = 8'h01; m_freq = pay[16:0]; end
                1: begin op = 8'h02; m_seed = (pay[22:0] == 23'd0) ? 23'd111 : pay[22:0]; end
                2: begin
                    op   = 8'h03;
                    m_en = pay[0];
                    if (pay[1]) begin m_ferr = 1'b0; m_err = 0; end
                end
                3: begin
                    op = 8'($urandom_range(0, 255));
                    while (op >= 8'h01 && op <= 8'h03) op = 8'($urandom_range(4, 255));
                    model_bad();
                end
                4: begin
                    op = 8'($urandom_range(1, 3));
                    nb = $urandom_range(0, 45);
                    if (nb == 40) nb = 0;
                    model_bad();
                end
                default: begin
                    op = 8'h02;
                    pay[22:0] = 23'd0;
                    m_seed = 23'd111;
                end
            endcase
            send_frame({24'd0, op, pay}, nb);
            repeat (6) @(negedge sys_clk);
            if (gen_enable === 1'b1 && $urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 30)) @(negedge sys_clk);
                gen_tick = 1'b1;
                @(negedge sys_clk);
                gen_tick = 1'b0;
            end
            for (int w = 0; w < T + 100 && cfg_busy === 1'b1; w++) @(negedge sys_clk);
            repeat (3) @(negedge sys_clk);
            check("rnd_busy_clear", cfg_busy, 0);
            exp_q.push_back(64'(m_freq));
            exp_q.push_back(64'(m_seed));
            exp_q.push_back(64'(m_en));
            exp_q.push_back(64'(m_ferr));
            exp_q.push_back(64'(m_err));
            check("rnd_freq", freq_div, exp_q.pop_front());
            check("rnd_seed", seed, exp_q.pop_front());
            check("rnd_enable", gen_enable, exp_q.pop_front());
            check("rnd_frame_err", frame_err, exp_q.pop_front());
            check("rnd_err_count", err_count, exp_q.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
